// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, frame
// deserialiser with parity/stop/timeout checking, and a first-word-fall-through scancode FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter int unsigned FIFO_AW        = 3
) (
  input  logic               mclk,
  input  logic               reset_in,
  input  logic               ps2_clk_i,
  input  logic               ps2_data_i,
  output logic [7:0]         code_o,
  output logic               code_valid_o,
  input  logic               code_rd_i,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic               frame_err_o,
  output logic               overflow_o,
  input  logic               clear_err_i
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt, r_filt_d;
  logic          w_fall;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bitcnt;
  logic          r_pbit;
  logic [TW-1:0] r_to_cnt;
  logic          w_push, w_err, w_timeout;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_full, w_empty, w_pop, w_wr;

  // Idle bus level is high on both lines, so synchronisers and filter reset to 1.
  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_cnt <= '0;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall    = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err       = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (((^r_shreg) ^ r_pbit) && r_dat_s2) w_push = 1'b1;
          else                                   w_err  = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_pbit      <= 1'b0;
      r_to_cnt    <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= w_err;
      if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bitcnt <= '0;
          S_DATA: begin
            r_shreg  <= {r_dat_s2, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          S_PARITY: r_pbit <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  assign w_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = code_rd_i & ~w_empty;
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge mclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (clear_err_i)                        overflow_o <= 1'b0;
      else if (w_push && w_full && !w_pop)    overflow_o <= 1'b1;
    end
  end

  assign fifo_count_o = r_count;
  assign code_valid_o = ~w_empty;
  assign code_o       = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven at a scaled bit rate, per-scenario inline checks.
module tb_ps2_rx_fifo;

  localparam int HALF = 40;
  localparam int TO   = 400;
  localparam int FL   = 8;

  logic       mclk = 1'b0;
  logic       reset_in, ps2_clk_i, ps2_data_i, code_rd_i, clear_err_i;
  logic [7:0] code_o;
  logic       code_valid_o, frame_err_o, overflow_o;
  logic [3:0] fifo_count_o;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  err_cnt = 0;
  int  lat = 0;
  time err_time = 0;
  time fall_time = 0;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_AW(3)) dut (
    .mclk(mclk), .reset_in(reset_in), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .code_o(code_o), .code_valid_o(code_valid_o), .code_rd_i(code_rd_i),
    .fifo_count_o(fifo_count_o), .frame_err_o(frame_err_o), .overflow_o(overflow_o),
    .clear_err_i(clear_err_i)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    if (frame_err_o) begin
      err_cnt  <= err_cnt + 1;
      err_time <= $time;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge mclk); #1; end
  endtask

  task automatic pop();
    code_rd_i = 1'b1; tick(1); code_rd_i = 1'b0;
  endtask

  // One PS/2 bit: data set in the high phase, then a low phase of HALF cycles.
  task automatic ps2_bit(input logic b, input bit glitch, input bit rd_en, input bit meas);
    ps2_data_i = b;
    if (glitch) begin
      tick(10); ps2_clk_i = 1'b0; tick(3); ps2_clk_i = 1'b1; tick(HALF - 13);
    end else begin
      tick(HALF);
    end
    ps2_clk_i = 1'b0;
    fall_time = $time;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge mclk); #1;
      if (rd_en) code_rd_i = (i == lat - 1);
      if (meas && lat == 0 && code_valid_o) lat = i;
    end
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int glitch_bit,
                            input bit rd_at_stop, input bit meas);
    logic [10:0] f;
    f = {1'b1, (~(^d)) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++)
      ps2_bit(f[i], glitch_bit == i, rd_at_stop && i == 10, meas && i == 10);
    ps2_data_i = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic test_reset();
    reset_in = 1'b1; ps2_clk_i = 1'b1; ps2_data_i = 1'b1; code_rd_i = 1'b0; clear_err_i = 1'b0;
    tick(5);
    n_cmp++;
    if ({code_o, code_valid_o, fifo_count_o, frame_err_o, overflow_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {code_o, code_valid_o, fifo_count_o, frame_err_o, overflow_o});
    end
    reset_in = 1'b0;
    tick(20);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, -1, 1'b0, 1'b1);
    n_cmp++;
    if (lat < FL + 2 || lat > FL + 5) begin
      n_bad++; $display("FAIL push_latency: got %0d expected %0d..%0d", lat, FL + 2, FL + 5);
    end
    n_cmp++;
    if ({code_o, code_valid_o, fifo_count_o} !== {8'h1C, 1'b1, 4'd1}) begin
      n_bad++;
      $display("FAIL single_frame: got code=%h valid=%b cnt=%0d expected 1c/1/1",
               code_o, code_valid_o, fifo_count_o);
    end
    pop();
    n_cmp++;
    if ({code_valid_o, fifo_count_o} !== 5'd0) begin
      n_bad++; $display("FAIL single_pop: got valid=%b cnt=%0d expected 0/0", code_valid_o, fifo_count_o);
    end
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (err_cnt !== e0 + 1 || fifo_count_o !== 4'd0) begin
      n_bad++; $display("FAIL parity_err: got errs=%0d cnt=%0d expected %0d/0", err_cnt - e0, fifo_count_o, 1);
    end
    send_frame(8'hF0, 1'b0, -1, 1'b0, 1'b0);
    n_cmp++;
    if ({code_o, fifo_count_o} !== {8'hF0, 4'd1} || err_cnt !== e0 + 1) begin
      n_bad++;
      $display("FAIL after_parity: got code=%h cnt=%0d errs=%0d expected f0/1/1", code_o, fifo_count_o, err_cnt - e0);
    end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, -1, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_count_o, overflow_o, code_o} !== {4'd8, 1'b1, 8'h01}) begin
      n_bad++;
      $display("FAIL overflow_set: got cnt=%0d ovf=%b head=%h expected 8/1/01", fifo_count_o, overflow_o, code_o);
    end
    clear_err_i = 1'b1; tick(1); clear_err_i = 1'b0;
    n_cmp++;
    if ({overflow_o, fifo_count_o} !== {1'b0, 4'd8}) begin
      n_bad++; $display("FAIL overflow_clear: got ovf=%b cnt=%0d expected 0/8", overflow_o, fifo_count_o);
    end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (code_o !== 8'(i)) begin
        n_bad++; $display("FAIL drain_%0d: got %h expected %h", i, code_o, 8'(i));
      end
      pop();
    end
    pop();
    n_cmp++;
    if ({code_valid_o, fifo_count_o} !== 5'd0) begin
      n_bad++; $display("FAIL empty_pop: got valid=%b cnt=%0d expected 0/0", code_valid_o, fifo_count_o);
    end
  endtask

  task automatic test_timeout();
    int  e0;
    int  waited;
    time dt;
    e0 = err_cnt;
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ps2_data_i = 1'b1;
    waited = 0;
    while (err_cnt == e0 && waited < TO + 200) begin tick(1); waited++; end
    dt = (err_time - fall_time) / 10;
    n_cmp++;
    if (err_cnt !== e0 + 1) begin
      n_bad++; $display("FAIL timeout_pulse: got %0d pulses expected 1", err_cnt - e0);
    end
    n_cmp++;
    if (dt < TO || dt > TO + 20) begin
      n_bad++; $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", dt, TO, TO + 20);
    end
    tick(20);
    send_frame(8'h5A, 1'b0, -1, 1'b0, 1'b0);
    n_cmp++;
    if ({code_o, fifo_count_o} !== {8'h5A, 4'd1} || err_cnt !== e0 + 1) begin
      n_bad++;
      $display("FAIL after_timeout: got code=%h cnt=%0d errs=%0d expected 5a/1/1", code_o, fifo_count_o, err_cnt - e0);
    end
    pop();
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    ps2_data_i = 1'b0;
    tick(10); ps2_clk_i = 1'b0; tick(3); ps2_clk_i = 1'b1; tick(10);
    ps2_data_i = 1'b1;
    tick(50);
    send_frame(8'h3C, 1'b0, 4, 1'b0, 1'b0);
    n_cmp++;
    if ({code_o, fifo_count_o} !== {8'h3C, 4'd1} || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL glitch_frame: got code=%h cnt=%0d errs=%0d expected 3c/1/0", code_o, fifo_count_o, err_cnt - e0);
    end
    pop();
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, -1, 1'b0, 1'b0);
    send_frame(8'h19, 1'b0, -1, 1'b1, 1'b0);
    n_cmp++;
    if ({fifo_count_o, overflow_o, code_o} !== {4'd8, 1'b0, 8'h12}) begin
      n_bad++;
      $display("FAIL full_rdwr: got cnt=%0d ovf=%b head=%h expected 8/0/12", fifo_count_o, overflow_o, code_o);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (code_o !== 8'h12 + 8'(i)) begin
        n_bad++; $display("FAIL full_drain_%0d: got %h expected %h", i, code_o, 8'h12 + 8'(i));
      end
      pop();
    end
    n_cmp++;
    if ({code_o, fifo_count_o} !== {8'h19, 4'd1}) begin
      n_bad++; $display("FAIL appended_byte: got code=%h cnt=%0d expected 19/1", code_o, fifo_count_o);
    end
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    reset_in = 1'b1;
    tick(3);
    n_cmp++;
    if ({code_o, code_valid_o, fifo_count_o, frame_err_o, overflow_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL midframe_reset: got %h expected 0",
               {code_o, code_valid_o, fifo_count_o, frame_err_o, overflow_o});
    end
    reset_in = 1'b0;
    ps2_data_i = 1'b1;
    tick(50);
    send_frame(8'h77, 1'b0, -1, 1'b0, 1'b0);
    n_cmp++;
    if ({code_o, fifo_count_o, overflow_o} !== {8'h77, 4'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL after_reset: got code=%h cnt=%0d ovf=%b expected 77/1/0", code_o, fifo_count_o, overflow_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_full_rdwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
